// File: rtl/fp_result_pkg.sv
// Shared fp32 field constants and class-code definitions for the calculation
// unit's result path.
package fp_result_pkg;

   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;
   localparam int MANT_W = 23;
   localparam logic [7:0] EXP_ALL1 = 8'hFF;

   localparam int CLS_NAN = 3;
   localparam int CLS_INF = 2;
   localparam int CLS_ZERO = 1;
   localparam int CLS_SUB = 0;

   typedef logic [3:0] fp_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single-precision classifier; one-hot class code,
// all-zero for ordinary normal numbers.
module fp32_classify
   import fp_result_pkg::*;
(
   input  logic [31:0] data_i,
   output fp_class_t   class_o
);

   logic [EXP_MSB-EXP_LSB:0] exponent;
   logic [MANT_W-1:0]        mantissa;

   assign exponent = data_i[EXP_MSB:EXP_LSB];
   assign mantissa = data_i[MANT_W-1:0];

   always_comb begin
      class_o = '0;
      if (exponent == EXP_ALL1) begin
         if (mantissa != '0) class_o[CLS_NAN] = 1'b1;
         else                class_o[CLS_INF] = 1'b1;
      end else if (exponent == '0) begin
         if (mantissa == '0) class_o[CLS_ZERO] = 1'b1;
         else                class_o[CLS_SUB]  = 1'b1;
      end
   end

endmodule

// File: rtl/fp_result_collector.sv
// Tags fp32 result beats with their class, buffers them in a FWFT FIFO and
// keeps saturating statistics on accepted, NaN, Inf and dropped beats.
module fp_result_collector
   import fp_result_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              s_axis_result_tdata,
   input  logic                     s_axis_result_tvalid,
   output logic                     s_axis_result_tready,
   output logic [31:0]              m_axis_tdata,
   output logic [3:0]               m_axis_tuser,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   input  logic                     clr_cnt,
   output logic [CNT_W-1:0]         total_cnt,
   output logic [CNT_W-1:0]         nan_cnt,
   output logic [CNT_W-1:0]         inf_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   fp_class_t      inClass;
   logic [35:0]    mem_q [DEPTH];
   logic [35:0]    headEntry;
   logic [PW-1:0]  wrPtr_q, wrPtr_d;
   logic [PW-1:0]  rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] totalCnt_q, totalCnt_d;
   logic [CNT_W-1:0] nanCnt_q, nanCnt_d;
   logic [CNT_W-1:0] infCnt_q, infCnt_d;
   logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
   logic empty, full, push, pop, drop;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                                input logic en);
      return (en && (value != {CNT_W{1'b1}})) ? value + 1'b1 : value;
   endfunction

   fp32_classify uClassify (
      .data_i  (s_axis_result_tdata),
      .class_o (inClass)
   );

   assign empty = (wrPtr_q == rdPtr_q);
   assign full  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
   assign push  = s_axis_result_tvalid && !full;
   assign drop  = s_axis_result_tvalid && full;
   assign pop   = !empty && m_axis_tready;

   // Empty output is forced to zero so reset is visible on the data path
   // without having to clear the storage array.
   assign headEntry            = mem_q[rdPtr_q[AW-1:0]];
   assign m_axis_tvalid        = !empty;
   assign m_axis_tdata         = empty ? '0 : headEntry[31:0];
   assign m_axis_tuser         = empty ? '0 : headEntry[35:32];
   assign s_axis_result_tready = !full;
   assign level                = wrPtr_q - rdPtr_q;
   assign total_cnt            = totalCnt_q;
   assign nan_cnt              = nanCnt_q;
   assign inf_cnt              = infCnt_q;
   assign drop_cnt             = dropCnt_q;

   always_comb begin
      wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d    = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
      totalCnt_d = satInc(totalCnt_q, push);
      nanCnt_d   = satInc(nanCnt_q, push && inClass[CLS_NAN]);
      infCnt_d   = satInc(infCnt_q, push && inClass[CLS_INF]);
      dropCnt_d  = satInc(dropCnt_q, drop);
      if (clr_cnt) begin
         totalCnt_d = '0;
         nanCnt_d   = '0;
         infCnt_d   = '0;
         dropCnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         totalCnt_q <= '0;
         nanCnt_q   <= '0;
         infCnt_q   <= '0;
         dropCnt_q  <= '0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         totalCnt_q <= totalCnt_d;
         nanCnt_q   <= nanCnt_d;
         infCnt_q   <= infCnt_d;
         dropCnt_q  <= dropCnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q[AW-1:0]] <= {inClass, s_axis_result_tdata};
   end

endmodule

// File: doc/fp_result_collector.md
# fp_result_collector

Downstream stage of the fp32 calculation unit. It accepts the AXI-Stream-style result beats (`tdata`/`tvalid`) produced by the floating-point core and tags each beat with an IEEE-754 class code. Tagged beats are buffered in a small first-word-fall-through FIFO and presented on a ready/valid output. Saturating statistics counters are kept for accepted, NaN, Inf and dropped beats, so software and benches can check result integrity without probing the core.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of each statistics counter
- `clk` input 1 — sole clock, rising edge
- `rst_n` input 1 — reset, asynchronous, active-low
- `s_axis_result_tdata` input 32 — fp32 result from the calculation core
- `s_axis_result_tvalid` input 1 — result beat valid
- `s_axis_result_tready` output 1 — collector can accept; equals `!full`
- `m_axis_tdata` output 32 — buffered result at FIFO head
- `m_axis_tuser` output 4 — class code of head entry: [3] NaN, [2] Inf, [1] zero, [0] subnormal; 0000 = normal
- `m_axis_tvalid` output 1 — FIFO not empty
- `m_axis_tready` input 1 — consumer accepts head entry
- `clr_cnt` input 1 — synchronous clear of all counters; does not clear the FIFO
- `total_cnt`, `nan_cnt`, `inf_cnt`, `drop_cnt` output CNT_W each — statistics counters
- `level` output $clog2(DEPTH)+1 — current FIFO occupancy

## Operation
- Classification is combinational on `s_axis_result_tdata`, with exp = [30:23] and mant = [22:0]:
  - exp=FF, mant≠0 → NaN (1000)
  - exp=FF, mant=0 → Inf (0100)
  - exp=00, mant=0 → zero (0010, either sign)
  - exp=00, mant≠0 → subnormal (0001)
  - anything else → 0000
- Push occurs when `tvalid && tready`; `{tuser, tdata}` (36 bits) is written at the write pointer.
- Pop occurs when `m_axis_tvalid && m_axis_tready`; the read pointer advances.
- The core may run non-blocking and ignore backpressure. A beat with `tvalid && !tready` is dropped and counts only in `drop_cnt`.
- Pointers are $clog2(DEPTH)+1 bits wide with a wrap bit:
  - empty: pointers equal
  - full: index bits equal and wrap bits differ
  - wrap-around is natural modulo 2·DEPTH
- Push and pop in the same cycle:
  - not empty and not full: both occur, `level` unchanged
  - full: pop only (`tready` is low), level decreases by 1 and `tready` rises the next cycle
  - empty: push only (no head to pop)
- Counters:
  - `total_cnt` +1 per push
  - `nan_cnt` / `inf_cnt` +1 per push of that class
  - `drop_cnt` +1 per dropped beat
  - all counters saturate at 2^CNT_W−1 and never wrap
- `clr_cnt` has priority: in the cycle it is high, every counter loads 0 and that cycle's increments are discarded. The FIFO and data path are unaffected.

## Timing
- Reset (asynchronous assert, synchronous release by the system):
  - pointers 0, `level` 0
  - `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tuser` 0
  - `s_axis_result_tready` 1
  - all counters 0
- Reset mid-operation discards the FIFO contents immediately; the output reads as empty in the same cycle.
- Latency: a beat pushed at edge N is visible on `m_axis_*` with `m_axis_tvalid`=1 after edge N (first-word-fall-through). No bubble between back-to-back beats.
- Throughput: one beat in and one beat out per cycle sustained.
- `tready`, `tvalid`, `level` and the counters are all registered-state-derived; there is no combinational path from `s_axis_result_tvalid` to `s_axis_result_tready`.
- `m_axis_tdata`/`tuser` hold stable while `tvalid && !tready`.

## Structure
- Package `fp_result_pkg` holds:
  - FP32 field constants (EXP_MSB=30, EXP_LSB=23, MANT_W=23, EXP_ALL1=8'hFF)
  - class bit indices (CLS_NAN=3, CLS_INF=2, CLS_ZERO=1, CLS_SUB=0)
  - the 4-bit class typedef
- Sub-module `fp32_classify` is purely combinational: 32-bit in, 4-bit class out. It is reusable by other stages.
- The FIFO storage, pointers and counters live in `fp_result_collector` itself.

## Test plan
- Basic flow: after reset, push 32'h40ACCCCD (2.7+2.7=5.4) with `m_axis_tready`=1 → after one edge `m_axis_tdata`=40ACCCCD, `tuser`=0000, `total_cnt`=1, then empty.
- Classes: push 7FC00000, 7F800000, 00000000, 00000001, 3F800000 → `tuser` 1000, 0100, 0010, 0001, 0000 in order; `nan_cnt`=1, `inf_cnt`=1, `total_cnt`=5.
- Full/drop: `m_axis_tready`=0, push 6 beats with DEPTH=4 → `level`=4, `tready`=0 after 4th, `drop_cnt`=2. Then drain → the first four values come out in order.
- Simultaneous push/pop at full: `level`=4, `tvalid`=1, `m_axis_tready`=1 → one pop, the incoming beat is dropped, `level`=3, `tready`=1 next cycle.
- Saturation/clear: with CNT_W=4, push 17 beats → `total_cnt`=15. Assert `clr_cnt` during a push → `total_cnt`=0 next cycle; the FIFO still holds that beat.
- Async reset with FIFO holding 3 entries: drop `rst_n` mid-cycle → `m_axis_tvalid`=0, `level`=0 and counters 0 without waiting for a clock edge.
